// File: rtl/led_blink_ctrl.sv
// LED controller: off, solid, continuous blink, or a counted burst of blinks,
// timed by an external tick strobe. All outputs derive from registered state.
module led_blink_ctrl #(
  parameter int ON_TICKS  = 5,
  parameter int OFF_TICKS = 5,
  parameter int BURST_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_mode,
  input  logic [BURST_W-1:0] cmd_burst,
  output logic               cmd_ready,
  output logic               led,
  output logic               busy,
  output logic               done
);

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PW        = $clog2(MAX_TICKS + 1);
  localparam logic [PW-1:0] ON_LAST  = PW'(ON_TICKS - 1);
  localparam logic [PW-1:0] OFF_LAST = PW'(OFF_TICKS - 1);
  localparam logic [BURST_W-1:0] REM_ONE = BURST_W'(1);

  typedef enum logic [1:0] {IDLE, SOLID, BLINK_ON, BLINK_OFF} state_t;

  state_t             state_reg;
  logic [PW-1:0]      phase_reg;
  logic               burst_reg;
  logic [BURST_W-1:0] remaining_reg;
  logic               led_reg;
  logic               done_reg;
  logic               accept;

  // burst_reg is only ever set while blinking, so it alone gates new commands
  assign cmd_ready = ~burst_reg;
  assign accept    = cmd_valid & ~burst_reg;
  assign busy      = (state_reg != IDLE);
  assign led       = led_reg;
  assign done      = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      phase_reg     <= '0;
      burst_reg     <= 1'b0;
      remaining_reg <= '0;
      led_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        // a tick coinciding with an accepted command is deliberately dropped
        phase_reg <= '0;
        case (cmd_mode)
          2'b00: begin
            state_reg     <= IDLE;
            led_reg       <= 1'b0;
            burst_reg     <= 1'b0;
            remaining_reg <= '0;
          end
          2'b01: begin
            state_reg     <= SOLID;
            led_reg       <= 1'b1;
            burst_reg     <= 1'b0;
            remaining_reg <= '0;
          end
          2'b10: begin
            state_reg     <= BLINK_ON;
            led_reg       <= 1'b1;
            burst_reg     <= 1'b0;
            remaining_reg <= '0;
          end
          default: begin
            if (cmd_burst != '0) begin
              state_reg     <= BLINK_ON;
              led_reg       <= 1'b1;
              burst_reg     <= 1'b1;
              remaining_reg <= cmd_burst;
            end else begin
              state_reg     <= IDLE;
              led_reg       <= 1'b0;
              burst_reg     <= 1'b0;
              remaining_reg <= '0;
              done_reg      <= 1'b1;
            end
          end
        endcase
      end else if (tick) begin
        case (state_reg)
          BLINK_ON: begin
            if (phase_reg == ON_LAST) begin
              state_reg <= BLINK_OFF;
              led_reg   <= 1'b0;
              phase_reg <= '0;
            end else begin
              phase_reg <= phase_reg + 1'b1;
            end
          end
          BLINK_OFF: begin
            if (phase_reg == OFF_LAST) begin
              phase_reg <= '0;
              if (!burst_reg) begin
                state_reg <= BLINK_ON;
                led_reg   <= 1'b1;
              end else if (remaining_reg > REM_ONE) begin
                remaining_reg <= remaining_reg - 1'b1;
                state_reg     <= BLINK_ON;
                led_reg       <= 1'b1;
              end else begin
                remaining_reg <= '0;
                burst_reg     <= 1'b0;
                state_reg     <= IDLE;
                led_reg       <= 1'b0;
                done_reg      <= 1'b1;
              end
            end else begin
              phase_reg <= phase_reg + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Scoreboard bench for led_blink_ctrl (ON=2, OFF=3): expected output-change
// events {cycle, led/busy/done/ready} are queued at command issue.
module tb_led_blink_ctrl;

  localparam int ON  = 2;
  localparam int OFF = 3;
  localparam int BW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          cmd_valid;
  logic [1:0]    cmd_mode;
  logic [BW-1:0] cmd_burst;
  logic          cmd_ready;
  logic          led;
  logic          busy;
  logic          done;

  led_blink_ctrl #(.ON_TICKS(ON), .OFF_TICKS(OFF), .BURST_W(BW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .cmd_valid(cmd_valid),
    .cmd_mode(cmd_mode), .cmd_burst(cmd_burst), .cmd_ready(cmd_ready),
    .led(led), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] v;   // {led, busy, done, cmd_ready}
  } ev_t;

  ev_t        exp_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [3:0] prev;
  bit         mon_en = 0;
  bit         hold_cmd = 0;
  int         tick_base = 0;
  int         acc = 0;

  // Monitor: every change of the output tuple must match the next queued event
  always @(negedge clk) begin
    logic [3:0] cur;
    ev_t e;
    if (mon_en) begin
      cur = {led, busy, done, cmd_ready};
      if (cur !== prev) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: cyc=%0d led/busy/done/rdy=%b, required no change", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.v !== cur) begin
            n_fail++;
            $display("FAIL event: got cyc=%0d led/busy/done/rdy=%b, required cyc=%0d %b", cyc, cur, e.cyc, e.v);
          end else begin
            $display("event ok: cyc=%0d led/busy/done/rdy=%b", cyc, cur);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic push(input int off, input logic [3:0] v);
    ev_t e;
    e.cyc = acc + off;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  // One negedge: regular tick every 4 clk after the last accept edge
  task automatic nxt();
    @(negedge clk);
    tick = (cyc + 1 > tick_base) && (((cyc + 1 - tick_base) % 4) == 0);
    if (!hold_cmd) cmd_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) nxt();
  endtask

  task automatic send_cmd(input logic [1:0] mode, input logic [BW-1:0] b, input bit ftick);
    @(negedge clk);
    tick_base = cyc + 1;
    acc       = cyc + 1;
    tick      = ftick;
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_burst = b;
    $display("cmd: cyc=%0d mode=%b burst=%0d tick=%0d", acc, mode, b, ftick);
  endtask

  task automatic chk(input string name, input logic got, input logic want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, got, want);
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_burst = '0;
    repeat (3) @(negedge clk);
    chk("reset_led", led, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    prev = 4'b0001;
    mon_en = 1;

    // Continuous blink: 8 clk lit, 12 clk dark, ready stays high, no done
    send_cmd(2'b10, 4'd0, 1'b0);
    push(0, 4'b1101); push(8, 4'b0101); push(20, 4'b1101); push(28, 4'b0101); push(40, 4'b1101);
    run(44);
    send_cmd(2'b00, 4'd0, 1'b0);
    push(0, 4'b0001);
    run(3);

    // Burst of 3: done after the 15th tick
    send_cmd(2'b11, 4'd3, 1'b0);
    push(0, 4'b1100); push(8, 4'b0100); push(20, 4'b1100); push(28, 4'b0100);
    push(40, 4'b1100); push(48, 4'b0100); push(60, 4'b0011); push(61, 4'b0001);
    run(66);

    // SOLID held during a burst of 1 is taken on the first ready edge
    send_cmd(2'b11, 4'd1, 1'b0);
    push(0, 4'b1100); push(8, 4'b0100); push(20, 4'b0011); push(21, 4'b1101);
    run(1);
    hold_cmd = 1; cmd_valid = 1'b1; cmd_mode = 2'b01;
    run(25);
    hold_cmd = 0;
    run(2);

    // From SOLID: blink, then SOLID with a coincident tick while in BLINK_OFF
    send_cmd(2'b10, 4'd0, 1'b0);
    push(8, 4'b0101);
    run(15);
    send_cmd(2'b01, 4'd0, 1'b1);
    push(0, 4'b1101);
    run(3);
    // BLINK with a coincident tick: the ignored tick means a full 2-tick ON phase
    send_cmd(2'b10, 4'd0, 1'b1);
    push(8, 4'b0101);
    run(10);
    send_cmd(2'b00, 4'd0, 1'b0);
    push(0, 4'b0001);
    run(3);

    // Zero-length burst: done only, busy never rises
    send_cmd(2'b11, 4'd0, 1'b0);
    push(0, 4'b0011); push(1, 4'b0001);
    run(4);

    // Reset mid-burst (remaining=2, led lit) with tick and cmd_valid on the same edge
    send_cmd(2'b11, 4'd3, 1'b0);
    push(0, 4'b1100); push(8, 4'b0100); push(20, 4'b1100); push(24, 4'b0001);
    run(23);
    @(negedge clk);
    rst = 1'b1; tick = 1'b1; cmd_valid = 1'b1; cmd_mode = 2'b10;
    @(negedge clk);
    rst = 1'b0; tick = 1'b0; cmd_valid = 1'b0;
    run(3);
    send_cmd(2'b10, 4'd0, 1'b0);
    push(0, 4'b1101); push(8, 4'b0101);
    run(10);
    send_cmd(2'b00, 4'd0, 1'b0);
    push(0, 4'b0001);
    run(4);

    // Maximum burst of 15 lit periods, no wrap
    send_cmd(2'b11, 4'd15, 1'b0);
    for (int k = 0; k < 15; k++) begin
      push(20 * k, 4'b1100);
      push(20 * k + 8, 4'b0100);
    end
    push(300, 4'b0011); push(301, 4'b0001);
    run(306);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: %0d events not seen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_blink_ctrl.md
LED_BLINK_CTRL -- requirements
Module: led_blink_ctrl

Interface
REQ-001 SHALL have parameter ON_TICKS, default 5, ticks LED is lit per blink period; legal range >= 1.
REQ-002 SHALL have parameter OFF_TICKS, default 5, ticks LED is dark per blink period; legal range >= 1.
REQ-003 SHALL have parameter BURST_W, default 4, width of burst count field.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port tick  input  1  one-cycle timebase strobe from upstream counter wrap; sampled only on clk rising edge.
REQ-007 SHALL have port cmd_valid  input  1  command present.
REQ-008 SHALL have port cmd_mode  input  2  command mode: 00 OFF, 01 SOLID, 10 BLINK (continuous), 11 BURST.
REQ-009 SHALL have port cmd_burst  input  BURST_W  number of blinks for BURST; ignored for other modes.
REQ-010 SHALL have port cmd_ready  output  1  command can be accepted this cycle.
REQ-011 SHALL have port led  output  1  LED drive, active-high, registered.
REQ-012 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse on burst completion.

Function
REQ-014 SHALL implement FSM states IDLE, SOLID, BLINK_ON, BLINK_OFF, plus a burst flag and a remaining-blinks counter of BURST_W bits.
REQ-015 SHALL use a phase counter of width $clog2(max(ON_TICKS,OFF_TICKS)+1), incremented only on cycles with tick=1.
REQ-016 SHALL accept a command on a clock edge where cmd_valid=1 and cmd_ready=1; the new state is visible on led the following cycle.
REQ-017 SHALL drive cmd_ready=1 in IDLE, SOLID, and continuous BLINK; cmd_ready=0 while a burst is in progress.
REQ-018 SHALL clear the phase counter on every accepted command; on an accept edge a coincident tick is ignored.
REQ-019 On accept: OFF -> IDLE; SOLID -> SOLID; BLINK -> BLINK_ON with burst flag clear; BURST with cmd_burst>0 -> BLINK_ON, burst flag set, remaining=cmd_burst.
REQ-020 BURST with cmd_burst=0 SHALL go to IDLE, with done=1 for exactly the following cycle.
REQ-021 In BLINK_ON, a tick with phase==ON_TICKS-1 SHALL move to BLINK_OFF and clear phase; otherwise a tick increments phase.
REQ-022 In BLINK_OFF, a tick with phase==OFF_TICKS-1 SHALL clear phase and move as follows: continuous mode -> BLINK_ON; burst with remaining>1 -> decrement remaining, BLINK_ON; burst with remaining==1 -> IDLE, remaining=0, done=1 next cycle.
REQ-023 The blink period SHALL equal exactly ON_TICKS+OFF_TICKS ticks, with ON_TICKS ticks lit.
REQ-024 SHALL hold led=1 in SOLID and BLINK_ON and led=0 in IDLE and BLINK_OFF, registered with the state (no combinational path from inputs to led).
REQ-025 SHALL keep done low except the single cycle after burst completion; continuous blink SHALL never pulse done.
REQ-026 Cycles without tick SHALL leave phase, state, and remaining unchanged unless a command is accepted.
REQ-027 remaining SHALL never wrap: maximum burst 2^BURST_W-1 produces exactly that many lit periods.

Reset
REQ-028 On a clock edge with rst=1: state=IDLE, phase=0, remaining=0, burst flag=0, led=0, busy=0, done=0, cmd_ready=1 from the next cycle.
REQ-029 rst SHALL take priority over cmd_valid and tick on the same edge, including mid-burst; no done pulse is generated by reset.

Verification
REQ-030 ON=2, OFF=3, tick every 4 clk; cmd BLINK -> led high 8 clk, low 12 clk, repeating; done never asserted; cmd_ready stays 1.
REQ-031 ON=2, OFF=3; cmd BURST, cmd_burst=3 -> exactly 3 lit periods of 2 ticks; cmd_ready=0 throughout; done=1 for one cycle after the 15th tick; then busy=0, led=0.
REQ-032 cmd BURST, cmd_burst=0 -> state IDLE, led=0, done=1 exactly one cycle after accept, busy never high.
REQ-033 Continuous BLINK in BLINK_OFF, then cmd SOLID on the same edge as a tick -> led=1 the next cycle, phase=0, tick not counted.
REQ-034 rst asserted mid-burst (remaining=2, led=1) -> the next cycle has led=0, busy=0, done=0, cmd_ready=1; a following BLINK cmd restarts with a full ON_TICKS lit phase.
REQ-035 cmd_valid held high with SOLID while a burst runs -> ignored until burst completion; accepted on the first edge with cmd_ready=1.
